// File: rtl/seg_scan_driver.sv
// Seven-segment feeder: 8-bit binary to 3-digit BCD via sequential double-dabble,
// then time-multiplexed onto a shared 4-bit digit bus with one-hot digit select.

module seg_dd_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [3:0]  digit,
  output logic [2:0]  digit_sel
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [11:0]      work_q,  work_d;
  logic [2:0]       iter_q,  iter_d;
  logic [11:0]      bcd_q,   bcd_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       sel_q,   sel_d;
  logic [2:0][3:0]  work_adj;

  // add-3 correction on each work nibble, taken before the shift
  for (genvar g = 0; g < 3; g++) begin : g_adj
    seg_dd_adj u_adj (.nib_i(work_q[4*g +: 4]), .nib_o(work_adj[g]));
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = value;
          work_d  = '0;
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {work_d, shift_d} = {work_adj, shift_q} << 1;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          bcd_d   = work_d;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // free-running scan, independent of the converter
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sel_d = sel_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      sel_d = {sel_q[1:0], sel_q[2]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      work_q  <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= 3'b001;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    digit = 4'h0;
    case (sel_q)
      3'b001: digit = bcd_q[3:0];
      3'b010: digit = (BLANK_LZ && bcd_q[11:4] == 8'h00) ? 4'hF : bcd_q[7:4];
      3'b100: digit = (BLANK_LZ && bcd_q[11:8] == 4'h0)  ? 4'hF : bcd_q[11:8];
      default: digit = 4'h0;
    endcase
  end

  assign busy      = (state_q == CONV);
  assign bcd       = bcd_q;
  assign digit_sel = sel_q;

endmodule
